// File: rtl/div_fsm.sv
// Sequential unsigned divider by repeated subtraction. A controller FSM
// drives the R/B/Q register datapath; operands arrive one after another on data_in.
module div_fsm #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             done,
  output logic             busy,
  output logic             div_by_zero
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    CHECK  = 3'd3,
    SUB    = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state;
  state_t           next_state;
  logic [WIDTH-1:0] r_reg;
  logic [WIDTH-1:0] b_reg;
  logic [WIDTH-1:0] q_reg;
  logic             dz_reg;
  logic             r_ge_b;

  assign r_ge_b = (r_reg >= b_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // start is only looked at in IDLE and DONE; DONE waits for it to drop.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = LOAD_A;
      LOAD_A:  next_state = LOAD_B;
      LOAD_B:  next_state = CHECK;
      CHECK:   next_state = (b_reg == '0) ? DONE : SUB;
      SUB:     if (!r_ge_b) next_state = DONE;
      DONE:    if (!start) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Subtraction is guarded by R>=B, so R cannot underflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_reg  <= '0;
      b_reg  <= '0;
      q_reg  <= '0;
      dz_reg <= 1'b0;
    end else begin
      case (state)
        LOAD_A: begin
          r_reg  <= data_in;
          q_reg  <= '0;
          dz_reg <= 1'b0;
        end
        LOAD_B: b_reg <= data_in;
        CHECK: begin
          if (b_reg == '0) begin
            q_reg  <= '1;
            dz_reg <= 1'b1;
          end
        end
        SUB: begin
          if (r_ge_b) begin
            r_reg <= r_reg - b_reg;
            q_reg <= q_reg + WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done        = (state == DONE);
    busy        = (state == LOAD_A) || (state == LOAD_B) ||
                  (state == CHECK)  || (state == SUB);
    quotient    = q_reg;
    remainder   = r_reg;
    div_by_zero = dz_reg;
  end

endmodule
